// File: rtl/fifo_rr_reader_if.sv
// Signal bundle between the round-robin reader, its three command FIFOs and
// the downstream display-scheduler stream.
interface fifo_rr_reader_if #(
    parameter int DATA_W = 8,
    parameter int NUM_Q  = 3
);
    // FIFO side: rdreq is a one-cycle pop strobe (at most one bit high, never to
    // an empty FIFO); q_bus carries the popped word one cycle later.
    // Stream side: a word transfers on any rising edge where out_valid &&
    // out_ready; once out_valid rises, out_data/out_qid hold until that edge.
    logic [NUM_Q-1:0]        empty;
    logic [NUM_Q*DATA_W-1:0] q_bus;
    logic [NUM_Q-1:0]        rdreq;
    logic [DATA_W-1:0]       out_data;
    logic [1:0]              out_qid;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        input  empty, q_bus, out_ready,
        output rdreq, out_data, out_qid, out_valid
    );

    modport slave (
        output empty, q_bus, out_ready,
        input  rdreq, out_data, out_qid, out_valid
    );
endinterface

// File: rtl/fifo_rr_reader.sv
// Round-robin drain of three command FIFOs onto a valid/ready stream, with a
// per-queue count of words accepted downstream.
module fifo_rr_reader #(
    parameter int DATA_W = 8,
    parameter int NUM_Q  = 3,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    fifo_rr_reader_if.master       bus,
    output logic [NUM_Q*CNT_W-1:0] served_cnt,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       last;
    logic [1:0]       pick;
    logic             found;
    logic             grant;
    logic [1:0]       c1;
    logic [1:0]       c2;
    logic [CNT_W-1:0] cnt [NUM_Q];

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // last doubles as the selected queue while a word is in flight.
    always_comb begin
        c1    = inc3(last);
        c2    = inc3(c1);
        found = 1'b0;
        pick  = c1;
        if (!bus.empty[c1]) begin
            found = 1'b1;
            pick  = c1;
        end else if (!bus.empty[c2]) begin
            found = 1'b1;
            pick  = c2;
        end else if (!bus.empty[last]) begin
            found = 1'b1;
            pick  = last;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && found && reset) begin
                    grant     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT:    state_nxt = S_PRESENT;
            S_PRESENT: if (bus.out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.rdreq = '0;
        if (grant) bus.rdreq[pick] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            last          <= 2'd2;
            bus.out_data  <= '0;
            bus.out_qid   <= 2'd0;
            bus.out_valid <= 1'b0;
            for (int i = 0; i < NUM_Q; i++) cnt[i] <= '0;
        end else begin
            state <= state_nxt;
            if (grant) last <= pick;
            if (state == S_WAIT) begin
                bus.out_data  <= bus.q_bus[last*DATA_W +: DATA_W];
                bus.out_qid   <= last + 2'd1;
                bus.out_valid <= 1'b1;
            end
            if (state == S_PRESENT && bus.out_ready) begin
                bus.out_valid <= 1'b0;
                cnt[last]     <= cnt[last] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_Q; g++) begin : g_cnt
        assign served_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule
